// File: rtl/coin_button_conditioner.sv
// coin_button_conditioner: synchronise, debounce and edge-detect the coin/Enter buttons into arbitrated one-cycle pulses
module coin_button_conditioner #(
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_r1_raw,
    input  logic btn_r2_raw,
    input  logic btn_enter_raw,
    output logic R1,
    output logic R2,
    output logic Enter,
    output logic coin_conflict
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    logic [2:0]       s1_q, s2_q, db_q, db_dly_q, db_d, rise;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic             pend_q, coin, want_enter;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            db_d[i]  = (s2_q[i] != db_q[i] && cnt_q[i] == CNT_MAX) ? s2_q[i] : db_q[i];
            cnt_d[i] = (s2_q[i] == db_q[i] || cnt_q[i] == CNT_MAX) ? '0 : cnt_q[i] + 1'b1;
        end
    end

    assign rise       = db_q & ~db_dly_q;
    assign coin       = rise[0] | rise[1];
    // A coin in the same cycle as Enter is credited first; Enter waits one cycle.
    assign want_enter = rise[2] | pend_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q          <= '0;
            s2_q          <= '0;
            db_q          <= '0;
            db_dly_q      <= '0;
            cnt_q         <= '{default: '0};
            pend_q        <= 1'b0;
            R1            <= 1'b0;
            R2            <= 1'b0;
            Enter         <= 1'b0;
            coin_conflict <= 1'b0;
        end else begin
            s1_q          <= {btn_enter_raw, btn_r2_raw, btn_r1_raw};
            s2_q          <= s1_q;
            db_q          <= db_d;
            db_dly_q      <= db_q;
            cnt_q         <= cnt_d;
            pend_q        <= want_enter & coin;
            R1            <= rise[0] & ~rise[1];
            R2            <= rise[1] & ~rise[0];
            Enter         <= want_enter & ~coin;
            coin_conflict <= rise[0] & rise[1];
        end
    end
endmodule
